fetch_sequencer: RTL

//   Drives the load side of the program-counter register: reads current PC, fetches the

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_perf_cnt.sv | 39 +++
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch sequencer.
//   - fetch_state_t : FSM states {S_ISSUE, S_REQ, S_HOLD, S_DRAIN}
//   - default ADDR_W / INSTR_W / PC_INC values
//   - PERF_CNT_W    : width of the optional performance counters
package fetch_pkg;

  localparam int ADDR_W_DEF  = 27;
  localparam int INSTR_W_DEF = 32;
  localparam int PC_INC_DEF  = 1;
  localparam int PERF_CNT_W  = 32;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: two saturating event counters for the fetch sequencer.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   i_fetch_inc       +1 to o_fetch_cnt this cycle
//   i_redirect_inc    +1 to o_redirect_cnt this cycle
//   o_fetch_cnt       accepted-instruction count, saturates at all-ones
//   o_redirect_cnt    redirect-cycle count, saturates at all-ones
module fetch_perf_cnt
  import fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_fetch_inc,
  input  logic                  i_redirect_inc,
  output logic [PERF_CNT_W-1:0] o_fetch_cnt,
  output logic [PERF_CNT_W-1:0] o_redirect_cnt
);

  logic [1:0]                 w_inc;
  logic [1:0][PERF_CNT_W-1:0] r_cnt;

  assign w_inc = {i_redirect_inc, i_fetch_inc};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt[gi] <= '0;
        end else if (w_inc[gi] && (r_cnt[gi] != {PERF_CNT_W{1'b1}})) begin
          r_cnt[gi] <= r_cnt[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign o_fetch_cnt    = r_cnt[0];
  assign o_redirect_cnt = r_cnt[1];

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: loads the PC register, fetches instruction words over a
// req/ack memory handshake and presents them to decode over valid/ready.
// Optional feature macro: FETCH_PERF_CNT_EN (adds o_fetch_cnt / o_redirect_cnt).
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   i_pc                           current PC
//   o_pc_load, o_pc_next           one-cycle PC load strobe and value
//   o_imem_req, o_imem_addr        memory read request (held until ack) and address
//   i_imem_ack, i_imem_data        read completion and data
//   o_instr_valid, o_instr,
//   o_instr_pc, i_instr_ready      decode handshake
//   i_redirect, i_redirect_pc      branch/jump taken pulse and target
//   i_stall                        suppress new fetch issue
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int PC_INC  = PC_INC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic               o_pc_load,
  output logic [ADDR_W-1:0]  o_pc_next,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [INSTR_W-1:0] i_imem_data,
  output logic               o_instr_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_instr_pc,
  input  logic               i_instr_ready,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  input  logic               i_stall
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] o_fetch_cnt,
  output logic [PERF_CNT_W-1:0] o_redirect_cnt
`endif
);

  localparam logic [ADDR_W-1:0] W_INC = ADDR_W'(PC_INC);

  fetch_state_t       r_state;
  fetch_state_t       w_state_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               w_issue;
  logic               w_capture;

  // A redirect in S_ISSUE keeps us there so the new PC is sampled next cycle.
  assign w_issue = (r_state == S_ISSUE) && !i_redirect && !i_stall;

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    o_pc_load    = 1'b0;
    o_pc_next    = '0;
    case (r_state)
      S_ISSUE: begin
        if (w_issue) w_state_next = S_REQ;
      end
      S_REQ: begin
        if (i_imem_ack) begin
          if (i_redirect) begin
            w_state_next = S_ISSUE;
          end else begin
            w_capture    = 1'b1;
            w_state_next = S_HOLD;
          end
        end else if (i_redirect) begin
          // Request already on the bus: finish it, then throw the data away.
          w_state_next = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (i_redirect) begin
          w_state_next = S_ISSUE;
        end else if (i_instr_ready) begin
          o_pc_load    = 1'b1;
          o_pc_next    = r_addr + W_INC;  // wraps at ADDR_W
          w_state_next = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (i_imem_ack) w_state_next = S_ISSUE;
      end
      default: w_state_next = S_ISSUE;
    endcase
    // Redirect wins over any sequential PC update in every state.
    if (i_redirect) begin
      o_pc_load = 1'b1;
      o_pc_next = i_redirect_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_ISSUE;
      r_addr     <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_issue) r_addr <= i_pc;
      if (w_capture) begin
        r_instr    <= i_imem_data;
        r_instr_pc <= r_addr;
      end
    end
  end

  // r_addr only changes in S_ISSUE, so the address is stable while req is high.
  assign o_imem_req    = (r_state == S_REQ) || (r_state == S_DRAIN);
  assign o_imem_addr   = r_addr;
  assign o_instr_valid = (r_state == S_HOLD);
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;

`ifdef FETCH_PERF_CNT_EN
  logic w_accept;

  // An accept overridden by a redirect does not count as a fetched instruction.
  assign w_accept = (r_state == S_HOLD) && i_instr_ready && !i_redirect;

  fetch_perf_cnt u_perf_cnt (
    .clk            (clk),
    .reset          (reset),
    .i_fetch_inc    (w_accept),
    .i_redirect_inc (i_redirect),
    .o_fetch_cnt    (o_fetch_cnt),
    .o_redirect_cnt (o_redirect_cnt)
  );
`endif

endmodule
